// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the register-hazard scoreboard.
// The optional macro SCOREBOARD_WB_BYPASS_EN is consumed by reg_scoreboard.sv.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;
    localparam int SB_CNT_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // r0 is hard-wired zero, so it never matches a tracked register.
    function automatic logic addr_match(input reg_addr_t a, input int unsigned idx);
        return (a != '0) && (a == reg_addr_t'(idx));
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One saturating up/down pending-writer counter.
// The net delta of the three inputs is applied in one step.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [1:0]       dec_amt;

    always_comb begin
        count_next = count_reg;
        err        = 1'b0;
        dec_amt    = 2'd0;
        if (inc && !dec_a && !dec_b) begin
            if (&count_reg)
                err = 1'b1;
            else
                count_next = count_reg + CNT_W'(1);
        end else begin
            // An increment cancels one decrement, so this never goes negative.
            dec_amt = {1'b0, dec_a} + {1'b0, dec_b} - {1'b0, inc};
            if ({{CNT_W{1'b0}}, dec_amt} > {2'b00, count_reg}) begin
                count_next = '0;
                err        = 1'b1;
            end else begin
                count_next = count_reg - CNT_W'(dec_amt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign count = count_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard beside ID: per-register pending writers and ID stall.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle WB retire clear a single-writer hazard.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int CNT_W    = SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [4:0]            id_raddr1,
    input  logic [4:0]            id_raddr2,
    input  logic [4:0]            id_waddr,
    input  logic                  id_fire,
    input  logic                  wb_retire,
    input  logic [4:0]            wb_waddr,
    input  logic                  kill_valid,
    input  logic [4:0]            kill_waddr,
    output logic                  id_stall,
    output logic [NUM_REGS-1:0]   pending_vec,
    output logic                  sb_overflow
);

    logic [CNT_W-1:0]    cnt     [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] err_vec;
    logic [NUM_REGS-1:0] hit_vec;
    logic                sb_overflow_reg;

    assign hit_vec[0]     = 1'b0;
    assign pending_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic nonzero;

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (id_fire    && addr_match(id_waddr,   gi)),
                .dec_a (wb_retire  && addr_match(wb_waddr,   gi)),
                .dec_b (kill_valid && addr_match(kill_waddr, gi)),
                .count (cnt[gi]),
                .err   (err_vec[gi])
            );

            assign nonzero         = (cnt[gi] != '0);
            assign pending_vec[gi] = nonzero;
`ifdef SCOREBOARD_WB_BYPASS_EN
            // Last outstanding writer commits now; regfile write-through supplies the value.
            assign hit_vec[gi] = nonzero &&
                                 !(wb_retire && addr_match(wb_waddr, gi) && (cnt[gi] == CNT_W'(1)));
`else
            assign hit_vec[gi] = nonzero;
`endif
        end
    endgenerate

    assign id_stall = id_valid && (hit_vec[id_raddr1] || hit_vec[id_raddr2]);

    // Issuing past a stall is a protocol error, flagged alongside counter saturation.
    always_ff @(posedge clk) begin
        if (reset)
            sb_overflow_reg <= 1'b0;
        else if ((|err_vec) || (id_fire && id_stall))
            sb_overflow_reg <= 1'b1;
    end

    assign sb_overflow = sb_overflow_reg;

endmodule
